poly1305_seq_ctrl: RTL and testbench

Sequencer for the shared Poly1305 arithmetic resources: the 130x128 limb multiplier and the mod 2^130-5 reducer. It accepts 16-byte message blocks over a valid/ready handshake. For each block it pads, adds and folds the block into the accumulator, launches the multiply, launches the reduce, and writes back the result. After the last block it performs the final reduction and adds s to produce the 128-bit tag. It sits between the AEAD top level (which supplies r/s from the ChaCha20 key block) and the external mult/reduce units, which it does not instantiate.

---
 rtl/poly1305_seq_ctrl_if.sv | 25 ++
 rtl/poly1305_seq_ctrl.sv | 102 ++++++++++
 tb/tb_poly1305_seq_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/poly1305_seq_ctrl_if.sv
// poly1305_seq_ctrl_if: block stream plus multiplier/reducer request-response bus
interface poly1305_seq_ctrl_if;
  logic blk_valid;
  logic blk_ready;
  logic [127:0] blk_data;
  logic [4:0] blk_len;
  logic blk_last;
  logic mul_start;
  logic [129:0] mul_a;
  logic [127:0] mul_b;
  logic [257:0] mul_product;
  logic mul_done;
  logic red_start;
  logic [257:0] red_value;
  logic [129:0] red_out;
  logic red_done;
  modport master (
    output blk_valid, blk_data, blk_len, blk_last, mul_product, mul_done, red_out, red_done,
    input blk_ready, mul_start, mul_a, mul_b, red_start, red_value
  );
  modport slave (
    input blk_valid, blk_data, blk_len, blk_last, mul_product, mul_done, red_out, red_done,
    output blk_ready, mul_start, mul_a, mul_b, red_start, red_value
  );
endinterface

// File: rtl/poly1305_seq_ctrl.sv
// poly1305_seq_ctrl: sequences pad/add/multiply/reduce per block and the final tag addition
module poly1305_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_load,
  input  logic [127:0] r_in,
  input  logic [127:0] s_in,
  poly1305_seq_ctrl_if.slave bus,
  output logic busy,
  output logic tag_valid,
  output logic [127:0] tag,
  output logic err
);
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [129:0] P = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;
  localparam logic [127:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  typedef enum logic [3:0] {
    IDLE, READY, ADD, MUL_REQ, MUL_WAIT, RED_REQ, RED_WAIT, FINAL, TAG, ERR
  } state_t;
  state_t state, nxt;
  logic [129:0] acc, h;
  logic [127:0] r, s, keep;
  logic [128:0] n, n_c;
  logic [130:0] t;
  logic last, hs, bad, kl, tmo;
  logic [CW-1:0] cnt;
  assign bus.blk_ready = state == READY && !key_load;
  assign bus.mul_start = state == MUL_REQ;
  assign bus.red_start = state == RED_REQ;
  assign busy = !(state == IDLE || state == READY || state == ERR);
  assign tag_valid = state == TAG;
  assign err = state == ERR;
  // block padding, accumulator add, final reduction and handshake decode
  always_comb begin
    hs = bus.blk_ready && bus.blk_valid;
    kl = key_load && !busy;
    bad = bus.blk_len > 5'd16 || (bus.blk_len == 5'd0 && !bus.blk_last);
    keep = bus.blk_len >= 5'd16 ? '1 : (128'd1 << {bus.blk_len, 3'b0}) - 128'd1;
    n_c = {1'b0, bus.blk_data & keep} | (129'd1 << {bus.blk_len, 3'b0});
    t = {1'b0, acc} + {2'b0, n};
    h = acc >= P ? acc - P : acc;
    tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  end
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  end
  // next-state logic; an early done in a REQ cycle skips the WAIT state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = key_load ? READY : IDLE;
      READY:    nxt = key_load ? READY : !hs ? READY : bad ? ERR : bus.blk_len == 5'd0 ? FINAL : ADD;
      ADD:      nxt = MUL_REQ;
      MUL_REQ:  nxt = bus.mul_done ? RED_REQ : MUL_WAIT;
      MUL_WAIT: nxt = bus.mul_done ? RED_REQ : tmo ? ERR : MUL_WAIT;
      RED_REQ:  nxt = bus.red_done ? (last ? FINAL : READY) : RED_WAIT;
      RED_WAIT: nxt = bus.red_done ? (last ? FINAL : READY) : tmo ? ERR : RED_WAIT;
      FINAL:    nxt = TAG;
      TAG:      nxt = key_load ? READY : IDLE;
      ERR:      nxt = key_load ? READY : ERR;
      default:  nxt = IDLE;
    endcase
  end
  // datapath registers: key, accumulator, operands, wait counter and tag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      r <= '0;
      s <= '0;
      n <= '0;
      last <= 1'b0;
      cnt <= '0;
      tag <= '0;
      bus.mul_a <= '0;
      bus.mul_b <= '0;
      bus.red_value <= '0;
    end else begin
      if (kl) begin
        r <= r_in & CLAMP;
        s <= s_in;
        acc <= '0;
        tag <= '0;
      end
      if (hs) begin
        n <= n_c;
        last <= bus.blk_last;
      end
      if (state == ADD) begin
        bus.mul_a <= t[130] ? t[129:0] + 130'd5 : t[129:0];
        bus.mul_b <= r;
      end
      if ((state == MUL_REQ || state == MUL_WAIT) && bus.mul_done) bus.red_value <= bus.mul_product;
      if ((state == RED_REQ || state == RED_WAIT) && bus.red_done) acc <= bus.red_out;
      if (state == FINAL) tag <= 128'(h + {2'b0, s});
      cnt <= ((nxt == MUL_REQ || nxt == RED_REQ) && nxt != state) ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_poly1305_seq_ctrl.sv
// tb_poly1305_seq_ctrl: scoreboard bench with behavioural multiplier/reducer model
module tb_poly1305_seq_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic key_load = 1'b0;
  logic [127:0] r_in = '0;
  logic [127:0] s_in = '0;
  logic busy, tag_valid, err;
  logic [127:0] tag;
  poly1305_seq_ctrl_if bif();
  poly1305_seq_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .key_load(key_load), .r_in(r_in), .s_in(s_in),
    .bus(bif), .busy(busy), .tag_valid(tag_valid), .tag(tag), .err(err)
  );
  always #5 clk = ~clk;
  localparam logic [257:0] P = 258'h3_ffffffff_ffffffff_ffffffff_fffffffb;
  localparam logic [129:0] NEAR = 130'h3_ffffffff_ffffffff_ffffffff_fffffffd;
  int tests = 0;
  int fails = 0;
  int ms_cnt = 0;
  int rs_cnt = 0;
  int tv_cnt = 0;
  logic [127:0] exp_tag[$];
  int mcnt = 0;
  int rcnt = 0;
  bit mul_en = 1'b1;
  bit red_force = 1'b0;
  logic [257:0] prod;
  logic [129:0] redv;
  task automatic check(input string name, input logic [257:0] got, input logic [257:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // 3-cycle multiplier/reducer model plus pulse monitor and tag scoreboard
  always @(negedge clk) begin
    bif.mul_done = 1'b0;
    bif.red_done = 1'b0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        bif.mul_product = prod;
        bif.mul_done = 1'b1;
      end
    end
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        bif.red_out = redv;
        bif.red_done = 1'b1;
      end
    end
    if (bif.mul_start) begin
      ms_cnt++;
      if (mul_en) begin
        mcnt = 3;
        prod = 258'(bif.mul_a) * 258'(bif.mul_b);
      end
    end
    if (bif.red_start) begin
      rs_cnt++;
      rcnt = 3;
      redv = red_force ? NEAR : 130'(bif.red_value % P);
    end
    if (tag_valid) begin
      tv_cnt++;
      if (exp_tag.size() > 0) check("tag", tag, exp_tag.pop_front());
      else check("tag_unexpected", tag_valid, 0);
    end
  end
  function automatic logic [127:0] blk(input string m, input int off, input int len);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = (i < len) ? m[off+i] : 8'h5a;
    return v;
  endfunction
  task automatic load(input logic [127:0] r, input logic [127:0] s);
    @(negedge clk);
    key_load = 1'b1;
    r_in = r;
    s_in = s;
    @(negedge clk);
    key_load = 1'b0;
    #1;
  endtask
  task automatic send(input logic [127:0] d, input logic [4:0] l, input logic lst);
    int k = 0;
    @(negedge clk);
    bif.blk_valid = 1'b1;
    bif.blk_data = d;
    bif.blk_len = l;
    bif.blk_last = lst;
    while (!bif.blk_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("blk_ready", bif.blk_ready, 1);
    @(posedge clk);
    #1 bif.blk_valid = 1'b0;
  endtask
  task automatic wait_mul();
    int k = 0;
    while (!bif.mul_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("mul_start_seen", bif.mul_start, 1);
  endtask
  task automatic wait_tag();
    int t0 = tv_cnt;
    int k = 0;
    while (tv_cnt == t0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("tag_pulse", tv_cnt - t0, 1);
  endtask
  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_blk_ready"}, bif.blk_ready, 0);
    check({pfx, "_mul_start"}, bif.mul_start, 0);
    check({pfx, "_red_start"}, bif.red_start, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_tag_valid"}, tag_valid, 0);
    check({pfx, "_err"}, err, 0);
    check({pfx, "_mul_a"}, bif.mul_a, 0);
    check({pfx, "_mul_b"}, bif.mul_b, 0);
    check({pfx, "_red_value"}, bif.red_value, 0);
    check({pfx, "_tag"}, tag, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    string msg;
    int m0, t0, r0;
    logic [127:0] d2;
    logic [130:0] sum;
    msg = "Cryptographic Forum Research Group";
    bif.blk_valid = 1'b0;
    bif.blk_data = '0;
    bif.blk_len = '0;
    bif.blk_last = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    // RFC 8439 vector, three blocks
    load(128'ha806d542fe52447f336d555778bed685, 128'h1bf54941aff6bf4afdb20dfb8a800301);
    exp_tag.push_back(128'ha927010caf8b2bc2c6365130c11d06a8);
    m0 = ms_cnt;
    send(blk(msg, 0, 16), 5'd16, 1'b0);
    send(blk(msg, 16, 16), 5'd16, 1'b0);
    send(blk(msg, 32, 2), 5'd2, 1'b1);
    wait_tag();
    check("rfc_mul_starts", ms_cnt - m0, 3);
    // empty message
    load(128'h1234, 128'hdeadbeef_00112233_44556677_8899aabb);
    exp_tag.push_back(128'hdeadbeef_00112233_44556677_8899aabb);
    m0 = ms_cnt;
    t0 = tv_cnt;
    send(128'hffff, 5'd0, 1'b1);
    wait_tag();
    repeat (4) @(negedge clk);
    check("empty_mul_starts", ms_cnt - m0, 0);
    check("empty_tv_once", tv_cnt - t0, 1);
    check("empty_tag_held", tag, 128'hdeadbeef_00112233_44556677_8899aabb);
    // r = 0, full block of 0xff
    load(128'h0, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    exp_tag.push_back(128'h0f0e0d0c_0b0a0908_07060504_03020100);
    send('1, 5'd16, 1'b1);
    wait_mul();
    check("r0_mul_a", bif.mul_a, 130'h1_ffffffff_ffffffff_ffffffff_ffffffff);
    check("r0_mul_b", bif.mul_b, 0);
    wait_tag();
    // multiplier timeout
    mul_en = 1'b0;
    load(128'h5, 128'h6);
    send(128'h77, 5'd16, 1'b0);
    wait_mul();
    repeat (7) @(negedge clk);
    check("tmo_err_early", err, 0);
    @(negedge clk);
    check("tmo_err", err, 1);
    check("tmo_blk_ready", bif.blk_ready, 0);
    check("tmo_mul_start", bif.mul_start, 0);
    load(128'h5, 128'h6);
    check("tmo_clr_err", err, 0);
    check("tmo_clr_ready", bif.blk_ready, 1);
    mul_en = 1'b1;
    // bad lengths
    send(128'h1, 5'd17, 1'b0);
    @(negedge clk);
    check("len17_err", err, 1);
    load(128'h5, 128'h6);
    send(128'h1, 5'd0, 1'b0);
    @(negedge clk);
    check("len0_nolast_err", err, 1);
    // accumulator near 2^130: fold on add and final subtraction
    red_force = 1'b1;
    load(128'h3, '1);
    exp_tag.push_back(128'h1);
    d2 = 128'hfedcba98_76543210_01234567_89abcdef;
    send(128'h42, 5'd16, 1'b0);
    send(d2, 5'd16, 1'b1);
    wait_mul();
    sum = {1'b0, NEAR} + {3'b001, d2};
    check("fold_mul_a", bif.mul_a, 130'(sum - (131'd1 << 130) + 131'd5));
    wait_tag();
    red_force = 1'b0;
    // reset during MUL_WAIT
    load(128'h9, 128'ha);
    send(128'hbeef, 5'd16, 1'b0);
    wait_mul();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("areset");
    r0 = rs_cnt;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_red_start", rs_cnt - r0, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_ready", bif.blk_ready, 0);
    check("post_reset_red_value", bif.red_value, 0);
    check("tags_consumed", exp_tag.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
